// File: rtl/ddc_pkg.sv
// Shared constants and FSM state types for the DDC back-end (requantiser and frame buffer).
package ddc_pkg;

    localparam int CIC_OUT_W = 44;
    localparam int IQ_W      = 16;
    localparam int FRAME_LEN = 256;
    localparam int ADDR_W    = 8;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/iq_sat_round.sv
// Round-half-up arithmetic right shift followed by a clamp to the signed output range.
module iq_sat_round #(
    parameter int IN_WIDTH  = 44,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 20
) (
    input  logic [IN_WIDTH-1:0]  x,
    output logic [OUT_WIDTH-1:0] y,
    output logic                 sat
);

    localparam logic [IN_WIDTH:0] RND = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_WIDTH:0] MAXV =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MINV =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [IN_WIDTH:0] sum;
    logic signed [IN_WIDTH:0] shr;

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    always_comb begin
        sum = $signed({x[IN_WIDTH-1], x}) + $signed(RND);
        shr = sum >>> SHIFT;
        sat = 1'b0;
        y   = shr[OUT_WIDTH-1:0];
        if (shr > MAXV) begin
            y   = MAXV[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else if (shr < MINV) begin
            y   = MINV[OUT_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/iq_requant_framer.sv
// Requantises CIC I/Q samples to 16 bits, frames them per PRT into a ping-pong RAM and
// replays each frame over a valid/ready stream with a last-sample marker.
//
// state    | meaning
// W_IDLE   | waiting for frame_start; samples discarded
// W_FILL   | writing samples into bank wbank at waddr
// R_IDLE   | waiting for bank rbank to become full
// R_STREAM | issuing RAM reads for bank rbank until the last beat is accepted
module iq_requant_framer
    import ddc_pkg::*;
#(
    parameter int IN_WIDTH  = ddc_pkg::CIC_OUT_W,
    parameter int OUT_WIDTH = ddc_pkg::IQ_W,
    parameter int SHIFT     = 20,
    parameter int FRAME_LEN = ddc_pkg::FRAME_LEN,
    parameter int ADDR_W    = ddc_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_i,
    input  logic [IN_WIDTH-1:0]  in_q,
    input  logic                 in_valid,
    input  logic                 frame_start,
    output logic [OUT_WIDTH-1:0] out_i,
    output logic [OUT_WIDTH-1:0] out_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 sat_flag,
    output logic                 frame_drop
);

    localparam int DW = 2 * OUT_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    logic [OUT_WIDTH-1:0] req_i, req_q, r_i, r_q;
    logic                 sat_i, sat_q, v1, fs1;

    iq_sat_round #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) u_round_i (
        .x(in_i), .y(req_i), .sat(sat_i)
    );
    iq_sat_round #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) u_round_q (
        .x(in_q), .y(req_q), .sat(sat_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i      <= '0;
            r_q      <= '0;
            v1       <= 1'b0;
            fs1      <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            r_i <= req_i;
            r_q <= req_q;
            v1  <= in_valid;
            fs1 <= frame_start;
            if (in_valid && (sat_i || sat_q))
                sat_flag <= 1'b1;
        end
    end

    wr_state_e         w_state, w_state_n;
    rd_state_e         r_state, r_state_n;
    logic [ADDR_W-1:0] waddr, waddr_n, wa;
    logic [ADDR_W-1:0] raddr, raddr_n, ra;
    logic              wbank, wbank_n, rbank, rbank_n;
    logic              rdone, rdone_n;
    logic [1:0]        full, full_n;
    logic              we, ren, capture, set_full, clr_full, drop_n;
    logic              rd_v, rd_last;
    logic [DW-1:0]     rdata;
    logic              o_v, s_v, o_last, s_last, pop, credit;
    logic [DW-1:0]     o_data, s_data;
    logic [1:0]        occ_n;

    always_comb begin
        w_state_n = w_state;
        waddr_n   = waddr;
        wbank_n   = wbank;
        wa        = waddr;
        we        = 1'b0;
        capture   = 1'b0;
        set_full  = 1'b0;
        drop_n    = 1'b0;
        if (w_state == W_IDLE) begin
            if (fs1) begin
                if (!full[wbank]) capture = 1'b1;
                else              drop_n  = 1'b1;
            end
        end else begin
            capture = 1'b1;
        end
        if (capture) begin
            w_state_n = W_FILL;
            // A frame_start in W_FILL restarts the same bank; a coincident sample is sample 0.
            if (fs1) begin
                wa      = '0;
                waddr_n = '0;
            end
            if (v1) begin
                we      = 1'b1;
                waddr_n = wa + 1'b1;
                if (wa == LAST_ADDR) begin
                    set_full  = 1'b1;
                    wbank_n   = ~wbank;
                    w_state_n = W_IDLE;
                end
            end
        end
    end

    // A read may issue only if the returning word is guaranteed a slot in out/skid.
    always_comb begin
        pop    = o_v && out_ready;
        occ_n  = 2'(o_v) + 2'(s_v) + 2'(rd_v) - 2'(pop);
        credit = (occ_n <= 2'd1);
    end

    always_comb begin
        r_state_n = r_state;
        raddr_n   = raddr;
        rbank_n   = rbank;
        rdone_n   = rdone;
        ra        = raddr;
        ren       = 1'b0;
        clr_full  = 1'b0;
        if (r_state == R_IDLE) begin
            if (full[rbank] && credit) begin
                ren       = 1'b1;
                ra        = '0;
                r_state_n = R_STREAM;
            end
        end else begin
            if (!rdone && credit)
                ren = 1'b1;
            if (pop && o_last) begin
                clr_full  = 1'b1;
                rbank_n   = ~rbank;
                r_state_n = R_IDLE;
            end
        end
        if (ren) begin
            raddr_n = ra + 1'b1;
            rdone_n = (ra == LAST_ADDR);
        end
        full_n = full;
        if (set_full) full_n[wbank] = 1'b1;
        if (clr_full) full_n[rbank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state    <= W_IDLE;
            waddr      <= '0;
            wbank      <= 1'b0;
            r_state    <= R_IDLE;
            raddr      <= '0;
            rbank      <= 1'b0;
            rdone      <= 1'b0;
            full       <= '0;
            rd_v       <= 1'b0;
            rd_last    <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            w_state    <= w_state_n;
            waddr      <= waddr_n;
            wbank      <= wbank_n;
            r_state    <= r_state_n;
            raddr      <= raddr_n;
            rbank      <= rbank_n;
            rdone      <= rdone_n;
            full       <= full_n;
            rd_v       <= ren;
            rd_last    <= ren && (ra == LAST_ADDR);
            frame_drop <= drop_n;
        end
    end

    logic [DW-1:0] mem [0:2*FRAME_LEN-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[{wbank, wa}] <= {r_i, r_q};
        if (ren)
            rdata <= mem[{rbank, ra}];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_v    <= 1'b0;
            s_v    <= 1'b0;
            o_last <= 1'b0;
            s_last <= 1'b0;
            o_data <= '0;
            s_data <= '0;
        end else if (o_v && !pop) begin
            if (!s_v && rd_v) begin
                s_v    <= 1'b1;
                s_data <= rdata;
                s_last <= rd_last;
            end
        end else if (s_v) begin
            o_v    <= 1'b1;
            o_data <= s_data;
            o_last <= s_last;
            s_v    <= rd_v;
            s_data <= rdata;
            s_last <= rd_last;
        end else begin
            o_v    <= rd_v;
            o_last <= rd_last;
            if (rd_v)
                o_data <= rdata;
        end
    end

    assign out_i     = o_data[DW-1:OUT_WIDTH];
    assign out_q     = o_data[OUT_WIDTH-1:0];
    assign out_valid = o_v;
    assign out_last  = o_last;

endmodule

// File: tb/tb_iq_requant_framer.sv
// Scoreboard bench for iq_requant_framer with 8-sample frames.
module tb_iq_requant_framer;

    localparam int FL = 8;
    localparam longint U = 64'sd1 <<< 20;
    localparam longint H = 64'sd1 <<< 19;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [43:0] in_i = '0, in_q = '0;
    logic        in_valid = 1'b0, frame_start = 1'b0, out_ready = 1'b0;
    logic [15:0] out_i, out_q;
    logic        out_valid, out_last, sat_flag, frame_drop;

    int n_checks = 0, n_errors = 0, beats = 0, drops = 0, rdy_mode = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    iq_requant_framer #(
        .IN_WIDTH(44), .OUT_WIDTH(16), .SHIFT(20), .FRAME_LEN(FL), .ADDR_W(3)
    ) dut (
        .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
        .frame_start(frame_start), .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .sat_flag(sat_flag), .frame_drop(frame_drop)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint req(input longint x);
        longint y;
        y = (x + H) >>> 20;
        if (y > 32767)       y = 32767;
        else if (y < -32768) y = -32768;
        return y;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 9) < 3);
        endcase
    end

    logic  prev_stall = 1'b0;
    beat_t prev_word;
    always @(negedge clk) begin
        beat_t e;
        if (frame_drop) drops++;
        if (rst && prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_word", {out_i, out_q, out_last}, prev_word);
        end
        prev_stall = rst && out_valid && !out_ready;
        prev_word  = {out_i, out_q, out_last};
        if (rst && out_valid && out_ready) begin
            beats++;
            check("sb_has_entry", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_i", $signed(out_i), $signed(e.i));
                check("out_q", $signed(out_q), $signed(e.q));
                check("out_last", out_last, e.last);
            end
        end
    end

    task automatic send(input longint xi, input longint xq, input bit fs);
        @(posedge clk); #1;
        in_i        = 44'(xi);
        in_q        = 44'(xq);
        in_valid    = 1'b1;
        frame_start = fs;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input longint xi[FL], input longint xq[FL],
                              input longint ei[FL], input longint eq[FL], input bit push);
        for (int k = 0; k < FL; k++) begin
            if (push) sb.push_back('{i: 16'(ei[k]), q: 16'(eq[k]), last: (k == FL - 1)});
            send(xi[k], xq[k], k == 0);
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint xi[FL], xq[FL], ei[FL], eq[FL];
        int d0, b0, b1, n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_i", out_i, 0);
        check("rst_q", out_q, 0);
        check("rst_last", out_last, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_drop", frame_drop, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        rdy_mode = 1;

        xi = '{3*U, 5*H, -5*H, 0, H-1, -H, 7*U+H, -1};
        ei = '{3, 3, -2, 0, 0, 0, 8, 0};
        for (int k = 0; k < FL; k++) begin
            xq[k] = (k + 1) * U;
            eq[k] = k + 1;
        end
        send_frame(xi, xq, ei, eq, 1);
        wait_drain(200, "round_drain");
        check("round_sat", sat_flag, 0);

        for (int k = 0; k < FL; k++) begin
            xi[k] = k * U;  xq[k] = -k * U;
            ei[k] = k;      eq[k] = -k;
        end
        send_frame(xi, xq, ei, eq, 1);
        wait_drain(200, "ramp_drain");
        check("ramp_sat", sat_flag, 0);

        xi = '{64'sd1 <<< 40, 32767*U, 32767*U+H, -32768*U, -32768*U-H, -32769*U, 0, 5*U};
        ei = '{32767, 32767, 32767, -32768, -32768, -32768, 0, 5};
        xq = '{-(64'sd1 <<< 40), 0, 0, 0, 0, 0, 0, -5*U};
        eq = '{-32768, 0, 0, 0, 0, 0, 0, -5};
        send_frame(xi, xq, ei, eq, 1);
        wait_drain(200, "sat_drain");
        check("sat_set", sat_flag, 1);

        rdy_mode = 2;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                xi[k] = longint'($signed($urandom)) <<< 3;
                xq[k] = longint'($signed($urandom)) <<< 3;
                ei[k] = req(xi[k]);
                eq[k] = req(xq[k]);
            end
            send_frame(xi, xq, ei, eq, 1);
        end
        wait_drain(3000, "bp_drain");
        rdy_mode = 1;
        check("sat_sticky", sat_flag, 1);

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        d0 = drops;
        b0 = beats;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < FL; k++) begin
                xi[k] = (100 * (f + 1) + k) * U;  xq[k] = -xi[k];
                ei[k] = 100 * (f + 1) + k;        eq[k] = -ei[k];
            end
            if (f == 2) check("pp_no_drop_yet", drops - d0, 0);
            send_frame(xi, xq, ei, eq, f < 2);
        end
        repeat (4) @(posedge clk);
        check("pp_drop_pulse", drops - d0, 1);
        @(negedge clk);
        check("pp_stalled_valid", out_valid, 1);
        rdy_mode = 1;
        wait_drain(300, "pp_drain");
        check("pp_beats", beats - b0, 2 * FL);

        for (int k = 0; k < FL; k++) begin
            xi[k] = (k + 10) * U;  xq[k] = -xi[k];
            ei[k] = k + 10;        eq[k] = -(k + 10);
        end
        b0 = beats;
        send_frame(xi, xq, ei, eq, 1);
        n = 0;
        while (beats < b0 + 4 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        check("mid_reach_beat4", beats - b0, 4);
        rst = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_i", out_i, 0);
        check("mid_rst_q", out_q, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_sat", sat_flag, 0);
        check("mid_rst_drop", frame_drop, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        b1 = beats;
        repeat (30) @(posedge clk);
        check("mid_no_stale", beats - b1, 0);
        check("mid_idle_valid", out_valid, 0);
        for (int k = 0; k < FL; k++) begin
            xi[k] = (k + 20) * U;  xq[k] = (k - 20) * U;
            ei[k] = k + 20;        eq[k] = k - 20;
        end
        send_frame(xi, xq, ei, eq, 1);
        wait_drain(200, "mid_new_drain");
        check("mid_new_beats", beats - b1, FL);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
